// File: rtl/gmii_frame_gen.sv
// GMII test-frame generator: preamble, SFD, header, incrementing payload, IFG.
// Define GMII_FRAME_GEN_FCS_EN to append an IEEE 802.3 CRC-32 FCS to each frame.
module gmii_frame_gen #(
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1514,
  parameter int IFG     = 12,
  parameter int CNT_W   = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic             stop,
  input  logic [10:0]      frame_len,
  input  logic [15:0]      num_frames,
  input  logic [47:0]      dst_mac,
  input  logic [47:0]      src_mac,
  input  logic [15:0]      ethertype,
  output logic [7:0]       gmii_txd,
  output logic             gmii_tx_en,
  output logic             gmii_tx_er,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frames_sent
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_HDR,
    S_PAY,
`ifdef GMII_FRAME_GEN_FCS_EN
    S_FCS,
`endif
    S_GAP
  } state_t;

  state_t             state_r, state_n_s;
  logic [15:0]        cnt_r, cnt_n_s;
  logic [10:0]        len_r;
  logic [15:0]        num_r;
  logic [111:0]       hdr_r;
  logic [7:0]         idx_r;
  logic               stop_r;
  logic [CNT_W-1:0]   frames_r;
  logic [7:0]         txd_r;
  logic               tx_en_r;
  logic               busy_r;
  logic               done_r;
  logic [7:0]         byte_s;
  logic               en_s;
  logic               last_s;
  logic               launch_s;
  logic               relatch_s;
  logic               run_end_s;
  logic [6:0]         hdr_idx_s;
`ifdef GMII_FRAME_GEN_FCS_EN
  logic [31:0]        crc_r;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction
`endif

  function automatic logic [10:0] clamp_len(input logic [10:0] l);
    logic [10:0] r;
    if (l < 11'(MIN_LEN)) begin
      r = 11'(MIN_LEN);
    end else if (l > 11'(MAX_LEN)) begin
      r = 11'(MAX_LEN);
    end else begin
      r = l;
    end
    return r;
  endfunction

  // Next-state logic and the byte presented for the current state/count
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r + 16'd1;
    byte_s    = 8'h00;
    en_s      = 1'b0;
    last_s    = 1'b0;
    launch_s  = 1'b0;
    relatch_s = 1'b0;
    hdr_idx_s = {4'd13 - cnt_r[3:0], 3'b000};
    run_end_s = stop_r | stop | ((num_r != 16'd0) && (frames_r == CNT_W'(num_r)));
    case (state_r)
      S_IDLE: begin
        cnt_n_s = 16'd0;
        if (start) begin
          state_n_s = S_PRE;
          launch_s  = 1'b1;
        end else begin
          state_n_s = S_IDLE;
        end
      end
      S_PRE: begin
        byte_s = 8'h55;
        en_s   = 1'b1;
        if (cnt_r == 16'd6) begin
          state_n_s = S_SFD;
          cnt_n_s   = 16'd0;
        end else begin
          state_n_s = S_PRE;
        end
      end
      S_SFD: begin
        byte_s    = 8'hD5;
        en_s      = 1'b1;
        state_n_s = S_HDR;
        cnt_n_s   = 16'd0;
      end
      S_HDR: begin
        // Header sent MSB byte first: DA, SA, EtherType
        byte_s = hdr_r[hdr_idx_s +: 8];
        en_s   = 1'b1;
        if (cnt_r == 16'd13) begin
          state_n_s = S_PAY;
          cnt_n_s   = 16'd0;
        end else begin
          state_n_s = S_HDR;
        end
      end
      S_PAY: begin
        byte_s = idx_r + cnt_r[7:0];
        en_s   = 1'b1;
        if (cnt_r == ({5'd0, len_r} - 16'd15)) begin
          cnt_n_s = 16'd0;
`ifdef GMII_FRAME_GEN_FCS_EN
          state_n_s = S_FCS;
`else
          state_n_s = S_GAP;
          last_s    = 1'b1;
`endif
        end else begin
          state_n_s = S_PAY;
        end
      end
`ifdef GMII_FRAME_GEN_FCS_EN
      S_FCS: begin
        byte_s = ~crc_r[{cnt_r[1:0], 3'b000} +: 8];
        en_s   = 1'b1;
        if (cnt_r == 16'd3) begin
          state_n_s = S_GAP;
          cnt_n_s   = 16'd0;
          last_s    = 1'b1;
        end else begin
          state_n_s = S_FCS;
        end
      end
`endif
      S_GAP: begin
        if (cnt_r == 16'(IFG - 1)) begin
          cnt_n_s = 16'd0;
          if (run_end_s) begin
            state_n_s = S_IDLE;
          end else begin
            state_n_s = S_PRE;
            relatch_s = 1'b1;
          end
        end else begin
          state_n_s = S_GAP;
        end
      end
      default: begin
        state_n_s = S_IDLE;
        cnt_n_s   = 16'd0;
      end
    endcase
  end

  // State and byte-counter register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= S_IDLE;
      cnt_r   <= 16'd0;
    end else begin
      state_r <= state_n_s;
      cnt_r   <= cnt_n_s;
    end
  end

  // Run configuration, frame index, sticky stop and frame counter
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      len_r    <= 11'd0;
      num_r    <= 16'd0;
      hdr_r    <= 112'd0;
      idx_r    <= 8'd0;
      stop_r   <= 1'b0;
      frames_r <= '0;
    end else begin
      if (launch_s) begin
        len_r    <= clamp_len(frame_len);
        num_r    <= num_frames;
        hdr_r    <= {dst_mac, src_mac, ethertype};
        idx_r    <= 8'd0;
        frames_r <= '0;
      end else if (relatch_s) begin
        len_r <= clamp_len(frame_len);
      end else if (last_s) begin
        idx_r    <= idx_r + 8'd1;
        frames_r <= frames_r + CNT_W'(1);
      end
      if (state_r == S_IDLE) begin
        stop_r <= 1'b0;
      end else if (stop) begin
        stop_r <= 1'b1;
      end
    end
  end

`ifdef GMII_FRAME_GEN_FCS_EN
  // CRC accumulates each DA..payload byte as it is registered out
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      crc_r <= 32'hFFFFFFFF;
    end else if (state_r == S_SFD) begin
      crc_r <= 32'hFFFFFFFF;
    end else if ((state_r == S_HDR) || (state_r == S_PAY)) begin
      crc_r <= crc32_byte(crc_r, byte_s);
    end
  end
`endif

  // Output registers; done marks the cycle busy drops
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      txd_r   <= 8'h00;
      tx_en_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      txd_r   <= byte_s;
      tx_en_r <= en_s;
      busy_r  <= (state_r != S_IDLE);
      done_r  <= (state_r == S_IDLE) && busy_r;
    end
  end

  assign gmii_txd    = txd_r;
  assign gmii_tx_en  = tx_en_r;
  assign gmii_tx_er  = 1'b0;
  assign busy        = busy_r;
  assign done        = done_r;
  assign frames_sent = frames_r;

endmodule

// File: doc/gmii_frame_gen.md
# gmii_frame_gen

Parametrised GMII test-frame generator for SGMII link bring-up on the KC705 Ethernet path. It drives the GMII transmit side of the 1000BASE-X/SGMII PCS/PMA in place of, or muxed against, the MAC. It emits a programmed number of Ethernet frames, each with preamble, SFD, header, incrementing payload, optional FCS and inter-frame gap. Transmitted-frame count and completion are reported to the control plane.

## Interface
Parameters:
- MIN_LEN, 60: minimum frame length in bytes, DA through end of payload, excluding FCS.
- MAX_LEN, 1514: maximum frame length, same basis.
- IFG, 12: idle cycles between frames; legal range is 12 or more.
- CNT_W, 32: width of the frames_sent counter.

Ports:
- aclk  in  1  125 MHz GMII clock; the only clock.
- aresetn  in  1  reset, asynchronous assert, active-low.
- start  in  1  begin a run; sampled only in IDLE.
- stop  in  1  end the run after the current frame and its IFG.
- frame_len  in  11  frame length in bytes; clamped to [MIN_LEN, MAX_LEN].
- num_frames  in  16  frames per run; 0 means continuous until stop.
- dst_mac  in  48  destination address.
- src_mac  in  48  source address.
- ethertype  in  16  EtherType/length field.
- gmii_txd  out  8  transmit data.
- gmii_tx_en  out  1  transmit enable.
- gmii_tx_er  out  1  transmit error; constant 0.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at the end of a run.
- frames_sent  out  CNT_W  number of frames completed in the current run.

## Operation
- FSM states: IDLE, PRE, SFD, HDR, PAY, FCS, GAP.
- IDLE -> PRE when start=1. On this transition:
  - frame_len (clamped), num_frames, both MACs and ethertype are latched.
  - frames_sent is cleared.
  - The frame index is set to 0.
- PRE: 7 bytes of 0x55. SFD: 1 byte of 0xD5.
- HDR: 14 bytes, each field sent MSB byte first: dst_mac[47:40] ... dst_mac[7:0], then src_mac, then ethertype.
- PAY: L-14 bytes, where L is the latched, clamped frame_len. Payload byte k = (frame_index[7:0] + k) mod 256.
- FCS: 4 bytes, described under Configuration.
- GAP: IFG cycles with tx_en=0 and txd=0x00.
- Leaving GAP:
  - To IDLE, pulsing done, if stop has been seen or frames_sent equals num_frames (num_frames ≠ 0).
  - Otherwise to PRE. frame_len is relatched at each PRE entry; the MACs and ethertype are not.
- frames_sent increments, wrapping, in the cycle the last byte of a frame is driven. frame_index increments at the same time.
- stop is sticky until IDLE. If stop arrives in IDLE it is ignored. If stop and the last byte occur in the same cycle, the run ends after that frame.
- start while busy is ignored.
- Asynchronous reset forces:
  - State to IDLE.
  - gmii_txd=0, gmii_tx_en=0, gmii_tx_er=0.
  - busy=0, done=0, frames_sent=0.
  - This applies immediately, even mid-frame. The truncated frame is not counted.

## Timing
- All outputs are registered.
- start is sampled high at edge N. The first 0x55 appears with tx_en=1 after edge N+1, and busy rises at the same point.
- tx_en stays high for exactly 8+L+4 contiguous cycles, or 8+L when FCS is compiled out.
- Between frames, tx_en is low for exactly IFG cycles.
- done is high for one cycle, coincident with busy falling.
- Clamp arithmetic is 11-bit unsigned:
  - frame_len < MIN_LEN uses MIN_LEN.
  - frame_len > MAX_LEN uses MAX_LEN.

## Configuration
- GMII_FRAME_GEN_FCS_EN defined: an IEEE 802.3 CRC-32 is appended.
  - Polynomial 0x04C11DB7, reflected, initial value 0xFFFFFFFF, computed over DA..payload.
  - The final complement ~crc is sent as 4 bytes, least-significant byte first.
  - CRC updates per byte, combinationally in the same cycle the byte is registered out, with no bubble before FCS.
- Not defined: the FCS state and CRC logic are absent. PAY goes directly to GAP and frames are 4 bytes shorter on the wire.

## Test plan
- Single frame: start with frame_len=60, num_frames=1, FCS_EN defined.
  - tx_en high 72 cycles; bytes 1–7 are 0x55, byte 8 is 0xD5.
  - Payload runs 0x00..0x2D.
  - zlib CRC-32 over DA..FCS equals 0x2144DF1C.
  - frames_sent=1; done pulses 12 cycles after tx_en falls.
- Clamping:
  - frame_len=20 gives 60-byte frames.
  - frame_len=2000 gives 1514-byte frames; tx_en is high for 1526 cycles.
- Multi-frame run: num_frames=3.
  - Exactly 12 idle cycles between frames.
  - Payload first bytes are 0x00, 0x01, 0x02.
  - frames_sent ends at 3; done pulses exactly once.
- Continuous with stop: num_frames=0, stop pulsed mid-way through frame 5.
  - Frame 5 completes with a valid FCS, then the IFG, then IDLE.
  - frames_sent=5; start while busy has no effect.
- Reset mid-frame: aresetn low during PAY.
  - tx_en, txd, busy and frames_sent go to 0 without waiting for a clock edge.
  - A new start produces a clean frame.
- Build without FCS_EN: frame_len=60 gives tx_en high for 68 cycles, the last byte is payload 0x2D, and gmii_tx_er is always 0.
